// File: rtl/fft_sequencer_pkg.sv
// Shared constants, state encoding and bit-reversal helper for the radix-2 DIT FFT sequencer.
// Every sequencer file imports this package so the FFT size is defined in one place.
package fft_sequencer_pkg;

    localparam int N           = 64;
    localparam int K           = 6;
    localparam int STAGE_WIDTH = 3;
    localparam int ADDR_WIDTH  = 7;

    // Terminal counts are compared explicitly, never reached by wrap-around.
    localparam logic [ADDR_WIDTH-1:0]  WORD_LAST  = ADDR_WIDTH'(2 * N - 1);
    localparam logic [K-1:0]           OP_LAST    = K'(N / 2 - 1);
    localparam logic [STAGE_WIDTH-1:0] STAGE_LAST = STAGE_WIDTH'(K - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_UNLOAD
    } fft_state_t;

    function automatic logic [K-1:0] bitrev_k(input logic [K-1:0] v);
        logic [K-1:0] r;
        r = '0;
        for (int i = 0; i < K; i++) begin
            r[i] = v[K-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_sequencer_bf_addr_gen.sv
// Combinational butterfly address and twiddle generator for one DIT stage/op pair.
// Pairs are 2^stage apart; twiddle steps are spread so the last stage uses every W_N index.
import fft_sequencer_pkg::*;

module fft_bf_addr_gen (
    input  logic [STAGE_WIDTH-1:0] stage,
    input  logic [K-1:0]           op_count,
    output logic [K-1:0]           o_addr_a,
    output logic [K-1:0]           o_addr_b,
    output logic [K-2:0]           o_tw_idx
);

    logic [K-1:0]           half;
    logic [K-1:0]           pos;
    logic [K-1:0]           grp;
    logic [STAGE_WIDTH-1:0] tw_shift;

    // pos < half <= 2^(K-1), so the top bit of pos never reaches the twiddle index.
    always_comb begin
        half     = K'(1) << stage;
        pos      = op_count & (half - K'(1));
        grp      = op_count >> stage;
        tw_shift = STAGE_LAST - stage;
        o_addr_a = ((grp << stage) << 1) | pos;
        o_addr_b = o_addr_a + half;
        o_tw_idx = pos[K-2:0] << tw_shift;
    end

endmodule

// File: rtl/fft_sequencer.sv
// Top-level FFT controller: bit-reversed LOAD, K stages of N/2 butterflies, natural-order UNLOAD.
// Butterfly addresses are computed from next-state counters and registered on entry to ISSUE.
import fft_sequencer_pkg::*;

module fft_sequencer (
    input  logic                   i_fft_base_clock,
    input  logic                   i_fft_reset_n,
    input  logic                   i_fft_start,
    input  logic                   i_bf_done,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic                   o_mem_we,
    output logic                   o_mem_rd,
    output logic                   o_bus_oe,
    output logic                   o_bf_start,
    output logic [K-1:0]           o_addr_a,
    output logic [K-1:0]           o_addr_b,
    output logic [K-2:0]           o_tw_idx,
    output logic [STAGE_WIDTH-1:0] stage,
    output logic [K-1:0]           opCount,
    output logic                   o_TIP,
    output logic                   o_busy,
    output logic                   o_done
);

    fft_state_t             state;
    fft_state_t             state_nxt;
    logic [ADDR_WIDTH-1:0]  word_cnt;
    logic [ADDR_WIDTH-1:0]  word_nxt;
    logic [STAGE_WIDTH-1:0] stage_nxt;
    logic [K-1:0]           op_nxt;
    logic [K-1:0]           gen_addr_a;
    logic [K-1:0]           gen_addr_b;
    logic [K-2:0]           gen_tw_idx;

    fft_bf_addr_gen u_addr_gen (
        .stage    (stage_nxt),
        .op_count (op_nxt),
        .o_addr_a (gen_addr_a),
        .o_addr_b (gen_addr_b),
        .o_tw_idx (gen_tw_idx)
    );

    always_ff @(posedge i_fft_base_clock or negedge i_fft_reset_n) begin
        if (!i_fft_reset_n) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            stage    <= '0;
            opCount  <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_nxt;
            stage    <= stage_nxt;
            opCount  <= op_nxt;
        end
    end

    // A done pulse only advances the counters from WAIT; in every other state it is dropped.
    always_comb begin
        state_nxt = state;
        word_nxt  = word_cnt;
        stage_nxt = stage;
        op_nxt    = opCount;
        case (state)
            S_IDLE: begin
                if (i_fft_start) begin
                    state_nxt = S_LOAD;
                    word_nxt  = '0;
                end
            end
            S_LOAD: begin
                if (word_cnt == WORD_LAST) begin
                    state_nxt = S_ISSUE;
                    word_nxt  = '0;
                    stage_nxt = '0;
                    op_nxt    = '0;
                end else begin
                    word_nxt = word_cnt + ADDR_WIDTH'(1);
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (i_bf_done) begin
                    if (opCount != OP_LAST) begin
                        op_nxt    = opCount + K'(1);
                        state_nxt = S_ISSUE;
                    end else if (stage != STAGE_LAST) begin
                        op_nxt    = '0;
                        stage_nxt = stage + STAGE_WIDTH'(1);
                        state_nxt = S_ISSUE;
                    end else begin
                        op_nxt    = '0;
                        stage_nxt = '0;
                        word_nxt  = '0;
                        state_nxt = S_UNLOAD;
                    end
                end
            end
            S_UNLOAD: begin
                if (word_cnt == WORD_LAST) begin
                    state_nxt = S_IDLE;
                    word_nxt  = '0;
                end else begin
                    word_nxt = word_cnt + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
                word_nxt  = '0;
                stage_nxt = '0;
                op_nxt    = '0;
            end
        endcase
    end

    // LOAD scatters complex pairs to bit-reversed slots, keeping re/im adjacent.
    always_comb begin
        o_mem_we   = (state == S_LOAD);
        o_mem_rd   = (state == S_UNLOAD);
        o_bf_start = (state == S_ISSUE);
        o_TIP      = (state == S_ISSUE) || (state == S_WAIT);
        o_busy     = (state != S_IDLE);
        o_done     = (state == S_UNLOAD) && (word_cnt == WORD_LAST);
        o_mem_addr = '0;
        if (state == S_LOAD) begin
            o_mem_addr = {bitrev_k(word_cnt[ADDR_WIDTH-1:1]), word_cnt[0]};
        end else if (state == S_UNLOAD) begin
            o_mem_addr = word_cnt;
        end
    end

    // Addresses stay frozen through WAIT so the butterfly unit sees them stable.
    always_ff @(posedge i_fft_base_clock or negedge i_fft_reset_n) begin
        if (!i_fft_reset_n) begin
            o_addr_a <= '0;
            o_addr_b <= '0;
            o_tw_idx <= '0;
        end else if (state_nxt == S_ISSUE) begin
            o_addr_a <= gen_addr_a;
            o_addr_b <= gen_addr_b;
            o_tw_idx <= gen_tw_idx;
        end
    end

    // Memory read data appears one cycle after the read, so the bus driver lags by one.
    always_ff @(posedge i_fft_base_clock or negedge i_fft_reset_n) begin
        if (!i_fft_reset_n) begin
            o_bus_oe <= 1'b0;
        end else begin
            o_bus_oe <= o_mem_rd;
        end
    end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed self-checking bench for fft_sequencer (N=64) with a 2-cycle butterfly model.
// Each transform is followed cycle by cycle; counts and captures are compared to hand values.
`timescale 1ns/1ps
module tb_fft_sequencer;

    logic       clock;
    logic       reset_n;
    logic       fft_start;
    logic       bf_done;
    logic [6:0] mem_addr;
    logic       mem_we;
    logic       mem_rd;
    logic       bus_oe;
    logic       bf_start;
    logic [5:0] addr_a;
    logic [5:0] addr_b;
    logic [4:0] tw_idx;
    logic [2:0] stage;
    logic [5:0] op_count;
    logic       tip;
    logic       busy;
    logic       done;

    int n_compared   = 0;
    int n_mismatched = 0;

    int we_cnt, rd_cnt, oe_cnt, tip_cnt, done_cnt, lag_err, done_edge;
    int bf_cnt [6];
    int load_addr [128];
    int cap_a [3], cap_b [3], cap_tw [3];
    int spur_op, spur_stage;
    bit done_seen, aborted, idle_oe, spur_en;
    logic [31:0] abort_outputs;

    fft_sequencer dut (
        .i_fft_base_clock (clock),
        .i_fft_reset_n    (reset_n),
        .i_fft_start      (fft_start),
        .i_bf_done        (bf_done),
        .o_mem_addr       (mem_addr),
        .o_mem_we         (mem_we),
        .o_mem_rd         (mem_rd),
        .o_bus_oe         (bus_oe),
        .o_bf_start       (bf_start),
        .o_addr_a         (addr_a),
        .o_addr_b         (addr_b),
        .o_tw_idx         (tw_idx),
        .stage            (stage),
        .opCount          (op_count),
        .o_TIP            (tip),
        .o_busy           (busy),
        .o_done           (done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Butterfly model: done is high in the second cycle after the bf_start cycle.
    initial begin
        int pend;
        pend    = 0;
        bf_done = 1'b0;
        forever begin
            @(negedge clock);
            bf_done = 1'b0;
            if (!reset_n) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) bf_done = 1'b1;
                end
                if (bf_start) begin
                    pend = 2;
                    if (spur_en && stage == 3'd2 && op_count == 6'd5) bf_done = 1'b1;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {mem_addr, mem_we, mem_rd, bus_oe, bf_start, addr_a, addr_b, tw_idx,
                stage, op_count, tip, busy, done} != '0;
    endfunction

    // Runs one transform from the start request, sampling every negedge.
    task automatic applyStimulus(input bit hold_start, input bit toggle_start,
                                 input bit spur_i, input bit abort_i);
        bit prev_rd, spur_pending;
        we_cnt = 0; rd_cnt = 0; oe_cnt = 0; tip_cnt = 0; done_cnt = 0; lag_err = 0;
        done_edge = -1; done_seen = 0; aborted = 0; idle_oe = 0;
        spur_op = -1; spur_stage = -1; spur_pending = 0; prev_rd = 0;
        for (int s = 0; s < 6; s++) bf_cnt[s] = 0;
        for (int c = 0; c < 3; c++) begin cap_a[c] = -1; cap_b[c] = -1; cap_tw[c] = -1; end
        spur_en = spur_i;
        @(negedge clock);
        checkOutput("busy_before_start", busy, 0);
        fft_start = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            @(negedge clock);
            fft_start = (toggle_start && tip) ? t[0] : hold_start;
            if (t == 0) checkOutput("busy_after_start", busy, 1);
            if (mem_we) begin
                if (we_cnt < 128) load_addr[we_cnt] = int'(mem_addr);
                we_cnt++;
            end
            if (mem_rd) rd_cnt++;
            if (bus_oe) oe_cnt++;
            if (bus_oe !== prev_rd) lag_err++;
            prev_rd = mem_rd;
            if (tip) tip_cnt++;
            if (spur_pending) begin
                spur_op = int'(op_count); spur_stage = int'(stage); spur_pending = 0;
            end
            if (bf_start) begin
                bf_cnt[stage]++;
                if (stage == 3'd0 && op_count == 6'd0) begin
                    cap_a[0] = int'(addr_a); cap_b[0] = int'(addr_b); cap_tw[0] = int'(tw_idx);
                end
                if (stage == 3'd1 && op_count == 6'd3) begin
                    cap_a[1] = int'(addr_a); cap_b[1] = int'(addr_b); cap_tw[1] = int'(tw_idx);
                end
                if (stage == 3'd5 && op_count == 6'd31) begin
                    cap_a[2] = int'(addr_a); cap_b[2] = int'(addr_b); cap_tw[2] = int'(tw_idx);
                end
                if (stage == 3'd2 && op_count == 6'd5) spur_pending = 1;
            end
            if (abort_i && tip && !bf_start && stage == 3'd3) begin
                reset_n = 1'b0;
                #1;
                abort_outputs = all_outputs();
                aborted = 1;
                break;
            end
            if (done) begin
                done_cnt++;
                done_seen = 1;
                done_edge = t + 1;
            end else if (done_seen && !busy) begin
                idle_oe = bus_oe;
                break;
            end
        end
    endtask

    task automatic checkTransform(input string name);
        checkOutput({name, "_finished"}, done_seen, 1);
        checkOutput({name, "_we_cycles"}, we_cnt, 128);
        checkOutput({name, "_tip_cycles"}, tip_cnt, 576);
        checkOutput({name, "_done_edge"}, done_edge, 128 + 576 + 128);
        checkOutput({name, "_done_pulses"}, done_cnt, 1);
        checkOutput({name, "_rd_cycles"}, rd_cnt, 128);
        checkOutput({name, "_oe_cycles"}, oe_cnt, 128);
        checkOutput({name, "_oe_lag_err"}, lag_err, 0);
        checkOutput({name, "_idle_oe"}, idle_oe, 1);
    endtask

    initial begin
        reset_n   = 1'b0;
        fft_start = 1'b0;
        spur_en   = 1'b0;
        #3;
        checkOutput("reset_outputs_nonzero", all_outputs(), 0);
        #2;
        reset_n = 1'b1;

        $display("[TB] run 1: normal transform with spurious done and start toggling");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkTransform("run1");
        checkOutput("load_w0", load_addr[0], 0);
        checkOutput("load_w2", load_addr[2], 64);
        checkOutput("load_w3", load_addr[3], 65);
        checkOutput("load_w127", load_addr[127], 127);
        for (int s = 0; s < 6; s++) checkOutput($sformatf("bf_pulses_stage%0d", s), bf_cnt[s], 32);
        checkOutput("s0op0_a", cap_a[0], 0);
        checkOutput("s0op0_b", cap_b[0], 1);
        checkOutput("s0op0_tw", cap_tw[0], 0);
        checkOutput("s1op3_a", cap_a[1], 5);
        checkOutput("s1op3_b", cap_b[1], 7);
        checkOutput("s1op3_tw", cap_tw[1], 16);
        checkOutput("s5op31_a", cap_a[2], 31);
        checkOutput("s5op31_b", cap_b[2], 63);
        checkOutput("s5op31_tw", cap_tw[2], 31);
        checkOutput("spur_op_after_issue", spur_op, 5);
        checkOutput("spur_stage_after_issue", spur_stage, 2);
        spur_en = 1'b0;

        $display("[TB] run 2: reset during stage 3 wait");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("abort_reached", aborted, 1);
        checkOutput("abort_outputs_nonzero", abort_outputs, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("abort_idle_busy", busy, 0);

        $display("[TB] run 3: full transform after abort, start held for back-to-back");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkTransform("run3");
        @(negedge clock);
        checkOutput("b2b_busy", busy, 1);
        checkOutput("b2b_we", mem_we, 1);
        checkOutput("b2b_addr", mem_addr, 0);
        checkOutput("b2b_oe_low", bus_oe, 0);
        fft_start = 1'b0;
        reset_n   = 1'b0;
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
